// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S transmit path: default sample width,
// frame length helper and the stereo sample pair type.
package i2s_pkg;

  localparam int unsigned I2S_WIDTH = 16;

  function automatic int unsigned frame_len(input int unsigned width);
    return 2 * width + 1;
  endfunction

  typedef struct packed {
    logic [I2S_WIDTH-1:0] left;
    logic [I2S_WIDTH-1:0] right;
  } stereo_t;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO with registered storage; occupancy is kept in its own
// counter so full/empty never depend on pointer arithmetic.
module sample_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/i2s_tx_feeder.sv
// Buffers stereo pairs and presents exactly one pair per I2S frame to the
// transmitter, updating only at the frame boundary.
module i2s_tx_feeder
  import i2s_pkg::*;
#(
  parameter int unsigned WIDTH          = I2S_WIDTH,
  parameter int unsigned FRAME_LEN      = frame_len(WIDTH),
  parameter int unsigned DEPTH          = 8,
  parameter bit          UNDERFLOW_ZERO = 1'b0
) (
  input  logic                      sclk_i,
  input  logic                      rst_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [WIDTH-1:0]          in_left_i,
  input  logic [WIDTH-1:0]          in_right_i,
  output logic [WIDTH-1:0]          leftChan_o,
  output logic [WIDTH-1:0]          rightChan_o,
  output logic                      frame_o,
  output logic [$clog2(DEPTH):0]    fill_o,
  output logic                      underflow_o
);

  localparam int unsigned CW = $clog2(FRAME_LEN);
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

  logic [CW-1:0]      frame_cnt;
  logic               boundary;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic [2*WIDTH-1:0] head;

  assign boundary   = (frame_cnt == LAST);
  assign push       = in_valid_i & ~fifo_full;
  // Pop decision uses the pre-edge occupancy, so a pair pushed into an empty
  // FIFO on the boundary edge waits for the following boundary.
  assign pop        = boundary & ~fifo_empty;
  assign in_ready_o = ~fifo_full;

  sample_fifo #(
    .WIDTH(2 * WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk     (sclk_i),
    .rst     (rst_i),
    .push    (push),
    .pop     (pop),
    .wr_data ({in_left_i, in_right_i}),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fill_o)
  );

  always_ff @(posedge sclk_i) begin
    if (rst_i) begin
      frame_cnt   <= '0;
      frame_o     <= 1'b0;
      leftChan_o  <= '0;
      rightChan_o <= '0;
      underflow_o <= 1'b0;
    end else begin
      frame_cnt <= boundary ? '0 : frame_cnt + 1'b1;
      frame_o   <= boundary;
      if (boundary) begin
        if (!fifo_empty) begin
          {leftChan_o, rightChan_o} <= head;
        end else begin
          underflow_o <= 1'b1;
          if (UNDERFLOW_ZERO) begin
            leftChan_o  <= '0;
            rightChan_o <= '0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx_feeder.sv
// Self-checking bench for i2s_tx_feeder: one DUT per underflow policy, fed
// identical stimulus and compared against a queue-based frame model.
module tb_i2s_tx_feeder;
  import i2s_pkg::*;

  localparam int unsigned W  = 16;
  localparam int unsigned FL = 33;
  localparam int unsigned D  = 4;

  logic          sclk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          in_valid_i = 1'b0;
  logic [W-1:0]  in_left_i = '0;
  logic [W-1:0]  in_right_i = '0;

  logic          h_ready, z_ready;
  logic [W-1:0]  h_left, h_right, z_left, z_right;
  logic          h_frame, z_frame;
  logic [2:0]    h_fill, z_fill;
  logic          h_uf, z_uf;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  stereo_t q[$];
  stereo_t m_hold, m_zero;
  bit      m_uf, m_frame, m_acc;
  int      m_cyc;

  always #5 sclk_i = ~sclk_i;

  i2s_tx_feeder #(.WIDTH(W), .FRAME_LEN(FL), .DEPTH(D), .UNDERFLOW_ZERO(1'b0)) u_hold (
    .sclk_i(sclk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(h_ready),
    .in_left_i(in_left_i), .in_right_i(in_right_i), .leftChan_o(h_left),
    .rightChan_o(h_right), .frame_o(h_frame), .fill_o(h_fill), .underflow_o(h_uf));

  i2s_tx_feeder #(.WIDTH(W), .FRAME_LEN(FL), .DEPTH(D), .UNDERFLOW_ZERO(1'b1)) u_zero (
    .sclk_i(sclk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(z_ready),
    .in_left_i(in_left_i), .in_right_i(in_right_i), .leftChan_o(z_left),
    .rightChan_o(z_right), .frame_o(z_frame), .fill_o(z_fill), .underflow_o(z_uf));

  // Drive one cycle (called at a falling edge), advance the model at the
  // rising edge, and return at the next falling edge for sampling.
  task automatic drive(input bit rst, input bit v, input logic [W-1:0] l, input logic [W-1:0] r);
    bit acc, bnd;
    rst_i = rst; in_valid_i = v; in_left_i = l; in_right_i = r;
    acc = !rst && v && (q.size() != D);
    bnd = (m_cyc % FL) == FL - 1;
    @(posedge sclk_i);
    if (rst) begin
      q.delete();
      m_hold = '0; m_zero = '0; m_uf = 0; m_frame = 0; m_cyc = 0; m_acc = 0;
    end else begin
      m_frame = bnd;
      if (bnd) begin
        if (q.size() != 0) begin
          m_hold = q.pop_front();
          m_zero = m_hold;
        end else begin
          m_uf = 1;
          m_zero = '0;
        end
      end
      if (acc) q.push_back('{left: l, right: r});
      m_acc = acc;
      m_cyc++;
    end
    @(negedge sclk_i);
  endtask

  task automatic idle();
    drive(0, 0, '0, '0);
  endtask

  task automatic do_reset();
    drive(1, 0, '0, '0);
    drive(1, 0, '0, '0);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({h_left, h_right, h_frame, h_fill, h_uf, h_ready} !== {32'h0, 1'b0, 3'd0, 1'b0, 1'b1}) begin
      n_errors++;
      $display("FAIL reset_hold: got l=%h r=%h f=%b fill=%0d uf=%b rdy=%b, want 0 0 0 0 0 1",
               h_left, h_right, h_frame, h_fill, h_uf, h_ready);
    end
    n_checks++;
    if ({z_left, z_right, z_frame, z_fill, z_uf, z_ready} !== {32'h0, 1'b0, 3'd0, 1'b0, 1'b1}) begin
      n_errors++;
      $display("FAIL reset_zero: got l=%h r=%h f=%b fill=%0d uf=%b rdy=%b, want 0 0 0 0 0 1",
               z_left, z_right, z_frame, z_fill, z_uf, z_ready);
    end
  endtask

  task automatic test_idle_frames();
    bit ef;
    do_reset();
    for (int k = 0; k < 99; k++) begin
      idle();
      ef = (k == 32) || (k == 65) || (k == 98);
      n_checks++;
      if (h_frame !== ef || z_frame !== ef) begin
        n_errors++;
        $display("FAIL idle_frame cyc=%0d: got %b/%b want %b", k, h_frame, z_frame, ef);
      end
      n_checks++;
      if (h_uf !== (k >= 32) || z_uf !== (k >= 32)) begin
        n_errors++;
        $display("FAIL idle_uf cyc=%0d: got %b/%b want %b", k, h_uf, z_uf, k >= 32);
      end
      n_checks++;
      if ({h_left, h_right, z_left, z_right} !== 64'h0) begin
        n_errors++;
        $display("FAIL idle_out cyc=%0d: got %h %h %h %h want 0", k, h_left, h_right, z_left, z_right);
      end
    end
  endtask

  task automatic test_single_push();
    do_reset();
    for (int k = 0; k < 33; k++) begin
      if (k == 5) drive(0, 1, 16'h1234, 16'hABCD);
      else idle();
      if (k == 5) begin
        n_checks++;
        if (h_fill !== 3'd1 || z_fill !== 3'd1) begin
          n_errors++;
          $display("FAIL single_fill: got %0d/%0d want 1", h_fill, z_fill);
        end
      end
    end
    n_checks++;
    if ({h_left, h_right, z_left, z_right} !== {16'h1234, 16'hABCD, 16'h1234, 16'hABCD}) begin
      n_errors++;
      $display("FAIL single_out: got %h %h / %h %h want 1234 abcd", h_left, h_right, z_left, z_right);
    end
    n_checks++;
    if ({h_fill, h_uf, h_frame, z_fill, z_uf, z_frame} !== {3'd0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1}) begin
      n_errors++;
      $display("FAIL single_state: got fill=%0d uf=%b f=%b / fill=%0d uf=%b f=%b want 0 0 1",
               h_fill, h_uf, h_frame, z_fill, z_uf, z_frame);
    end
  endtask

  task automatic test_back_to_back();
    stereo_t p[5];
    int idx, j;
    for (int i = 0; i < 5; i++) p[i] = stereo_t'($urandom);
    do_reset();
    idx = 0; j = 0;
    for (int k = 0; k < 170; k++) begin
      if (idx < 5) drive(0, 1, p[idx].left, p[idx].right);
      else idle();
      if (m_acc) idx++;
      if (k >= 3 && k <= 31) begin
        n_checks++;
        if (h_ready !== 1'b0) begin
          n_errors++;
          $display("FAIL b2b_ready_low cyc=%0d: got %b want 0", k, h_ready);
        end
      end
      if (k == 32) begin
        n_checks++;
        if (h_fill !== 3'd3 || h_ready !== 1'b1 || idx != 4) begin
          n_errors++;
          $display("FAIL b2b_full_pop: got fill=%0d rdy=%b acc=%0d want 3 1 4", h_fill, h_ready, idx);
        end
      end
      if (k == 33) begin
        n_checks++;
        if (h_fill !== 3'd4 || idx != 5) begin
          n_errors++;
          $display("FAIL b2b_fifth: got fill=%0d acc=%0d want 4 5", h_fill, idx);
        end
      end
      if (k % 33 == 32) begin
        n_checks++;
        if ({h_left, h_right} !== p[j] || {z_left, z_right} !== p[j] || h_frame !== 1'b1) begin
          n_errors++;
          $display("FAIL b2b_order j=%0d: got %h%h / %h%h f=%b want %h f=1",
                   j, h_left, h_right, z_left, z_right, h_frame, p[j]);
        end
        j++;
      end
    end
  endtask

  task automatic test_underflow_policy();
    do_reset();
    drive(0, 1, 16'h0001, 16'h0002);
    for (int k = 1; k < 66; k++) idle();
    n_checks++;
    if ({h_left, h_right} !== {16'h0001, 16'h0002}) begin
      n_errors++;
      $display("FAIL uf_hold: got %h %h want 0001 0002", h_left, h_right);
    end
    n_checks++;
    if ({z_left, z_right} !== 32'h0) begin
      n_errors++;
      $display("FAIL uf_zero: got %h %h want 0 0", z_left, z_right);
    end
    n_checks++;
    if (h_uf !== 1'b1 || z_uf !== 1'b1) begin
      n_errors++;
      $display("FAIL uf_flag: got %b/%b want 1", h_uf, z_uf);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 50; k++) begin
      if (k < 4) drive(0, 1, 16'(k + 16'h10), 16'(k + 16'h20));
      else idle();
    end
    n_checks++;
    if (h_fill !== 3'd3) begin
      n_errors++;
      $display("FAIL mid_prefill: got %0d want 3", h_fill);
    end
    drive(1, 1, 16'hFFFF, 16'hFFFF);
    n_checks++;
    if ({h_fill, h_left, h_right, h_uf, h_ready, h_frame} !== {3'd0, 32'h0, 1'b0, 1'b1, 1'b0}) begin
      n_errors++;
      $display("FAIL mid_reset: got fill=%0d l=%h r=%h uf=%b rdy=%b f=%b want 0 0 0 0 1 0",
               h_fill, h_left, h_right, h_uf, h_ready, h_frame);
    end
    for (int k = 0; k < 33; k++) begin
      idle();
      n_checks++;
      if (h_frame !== (k == 32)) begin
        n_errors++;
        $display("FAIL mid_frame cyc=%0d: got %b want %b", k, h_frame, k == 32);
      end
    end
  endtask

  task automatic test_random();
    bit v, r;
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      r = ($urandom_range(0, 399) == 0);
      v = (k % 400 < 40) ? 1'b1 : ($urandom_range(0, 29) == 0);
      drive(r, v, 16'($urandom), 16'($urandom));
      n_checks++;
      if ({h_left, h_right} !== m_hold || {z_left, z_right} !== m_zero) begin
        n_errors++;
        $display("FAIL rand_data cyc=%0d: got %h%h / %h%h want %h / %h",
                 k, h_left, h_right, z_left, z_right, m_hold, m_zero);
      end
      n_checks++;
      if (h_fill !== 3'(q.size()) || z_fill !== 3'(q.size()) ||
          h_ready !== (q.size() != D) || z_ready !== (q.size() != D)) begin
        n_errors++;
        $display("FAIL rand_fill cyc=%0d: got %0d/%0d rdy=%b/%b want %0d", k, h_fill, z_fill,
                 h_ready, z_ready, q.size());
      end
      n_checks++;
      if (h_frame !== m_frame || z_frame !== m_frame || h_uf !== m_uf || z_uf !== m_uf) begin
        n_errors++;
        $display("FAIL rand_flags cyc=%0d: got f=%b/%b uf=%b/%b want f=%b uf=%b",
                 k, h_frame, z_frame, h_uf, z_uf, m_frame, m_uf);
      end
    end
  endtask

  initial begin
    m_hold = '0; m_zero = '0; m_uf = 0; m_frame = 0; m_acc = 0; m_cyc = 0;
    test_reset();
    test_idle_frames();
    test_single_push();
    test_back_to_back();
    test_underflow_policy();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
